// File: rtl/npc_bp_pkg.sv
// Shared definitions for the next-PC / branch-prediction slice: default vectors
// and the 2-bit saturating counter encoding used by the BTB.
package npc_bp_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      ctr_e n;
      case (c)
         CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
         default: n = CTR_WNT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup for F, same-cycle
// update from E. Lookup reads the pre-update contents (no bypass).
module npc_btb
   import npc_bp_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int IDX_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:2] i_lk_pc,
   output logic            o_lk_hit,
   output ctr_e            o_lk_ctr,
   output logic [PC_W-1:0] o_lk_target,
   input  logic            i_up_en,
   input  logic [PC_W-1:2] i_up_pc,
   input  logic            i_up_taken,
   input  logic [PC_W-1:0] i_up_target
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic              r_valid  [DEPTH];
   ctr_e              r_ctr    [DEPTH];
   logic [TAG_W-1:0]  r_tag    [DEPTH];
   logic [PC_W-1:0]   r_target [DEPTH];

   logic [IDX_W-1:0]  w_lk_idx;
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_up_hit;

   assign w_lk_idx    = i_lk_pc[IDX_W+1:2];
   assign o_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == i_lk_pc[PC_W-1:IDX_W+2]);
   assign o_lk_ctr    = r_ctr[w_lk_idx];
   assign o_lk_target = r_target[w_lk_idx];

   assign w_up_idx = i_up_pc[IDX_W+1:2];
   assign w_up_tag = i_up_pc[PC_W-1:IDX_W+2];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // Valid bits and counters: cleared on reset, trained or allocated on resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= CTR_WNT;
         end
      end else if (i_up_en) begin
         if (w_up_hit) begin
            r_ctr[w_up_idx] <= ctr_next(r_ctr[w_up_idx], i_up_taken);
         end else if (i_up_taken) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= CTR_WT;
         end
      end
   end

   // Tag/target payload only matters once valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (i_up_en && !w_up_hit && i_up_taken) begin
         r_tag[w_up_idx]    <= w_up_tag;
         r_target[w_up_idx] <= i_up_target;
      end
   end

endmodule

// File: rtl/npc_bp.sv
// Fetch-stage PC generation with BTB prediction, delay-slot handling, E-stage
// mispredict recovery, D-stage jumps, exception/eret redirects and perf counters.
module npc_bp
   import npc_bp_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              IDX_W    = 6,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
   parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF),
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   output logic [PC_W-1:0]  F_PC,
   output logic             F_pred_taken,
   input  logic             D_jump,
   input  logic [PC_W-1:0]  D_jump_target,
   input  logic             E_valid,
   input  logic             E_is_branch,
   input  logic             E_taken,
   input  logic             E_pred_taken,
   input  logic [PC_W-1:0]  E_PC,
   input  logic [PC_W-1:0]  E_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [PC_W-1:0]  epc,
   output logic             flush_fd,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [PC_W-1:0]  PC_FOUR  = {{(PC_W-3){1'b0}}, 3'b100};
   localparam logic [PC_W-1:0]  PC_EIGHT = {{(PC_W-4){1'b0}}, 4'b1000};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0]  r_pc;
   logic             r_pend_valid;
   logic [PC_W-1:0]  r_pend_target;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_mispred_cnt;

   logic             w_btb_hit;
   ctr_e             w_btb_ctr;
   logic [PC_W-1:0]  w_btb_target;
   logic             w_pred_taken;
   logic             w_br_resolve;
   logic             w_mispred;
   logic [PC_W-1:0]  w_correct_pc;
   logic [PC_W-1:0]  w_pc_nxt;
   logic             w_pend_valid_nxt;
   logic [PC_W-1:0]  w_pend_target_nxt;
   logic             w_flush;

   npc_btb #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W)
   ) u_btb (
      .clk         (clk),
      .rst_n       (reset),
      .i_lk_pc     (r_pc[PC_W-1:2]),
      .o_lk_hit    (w_btb_hit),
      .o_lk_ctr    (w_btb_ctr),
      .o_lk_target (w_btb_target),
      .i_up_en     (w_br_resolve),
      .i_up_pc     (E_PC[PC_W-1:2]),
      .i_up_taken  (E_taken),
      .i_up_target (E_target)
   );

   // While a redirect is pending, F_PC is a delay slot and must not predict.
   assign w_pred_taken = w_btb_hit && w_btb_ctr[1] && !r_pend_valid;
   assign w_br_resolve = E_valid && E_is_branch;
   assign w_mispred    = w_br_resolve && (E_taken != E_pred_taken);
   assign w_correct_pc = E_taken ? E_target : (E_PC + PC_EIGHT);

   // Next-PC priority mux; redirects from E and exceptions override stall.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      w_flush           = 1'b0;
      if (exc_req) begin
         w_pc_nxt         = EXC_VEC;
         w_pend_valid_nxt = 1'b0;
         w_flush          = 1'b1;
      end else if (eret_req) begin
         w_pc_nxt         = epc;
         w_pend_valid_nxt = 1'b0;
         w_flush          = 1'b1;
      end else if (w_mispred) begin
         w_pc_nxt         = w_correct_pc;
         w_pend_valid_nxt = 1'b0;
         w_flush          = !stall;
      end else if (D_jump && !stall) begin
         w_pc_nxt         = D_jump_target;
         w_pend_valid_nxt = 1'b0;
      end else if (stall) begin
         w_pc_nxt         = r_pc;
      end else if (r_pend_valid) begin
         w_pc_nxt         = r_pend_target;
         w_pend_valid_nxt = 1'b0;
      end else if (w_pred_taken) begin
         w_pc_nxt          = r_pc + PC_FOUR;
         w_pend_valid_nxt  = 1'b1;
         w_pend_target_nxt = w_btb_target;
      end else begin
         w_pc_nxt         = r_pc + PC_FOUR;
      end
   end

   // PC and pending-redirect state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc          <= RESET_PC;
         r_pend_valid  <= 1'b0;
         r_pend_target <= RESET_PC;
      end else begin
         r_pc          <= w_pc_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_br_resolve && (r_br_cnt != {CNT_W{1'b1}})) begin
            r_br_cnt <= r_br_cnt + CNT_ONE;
         end
         if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
         end
      end
   end

   assign F_PC         = r_pc;
   assign F_pred_taken = w_pred_taken;
   assign flush_fd     = w_flush;
   assign br_cnt       = r_br_cnt;
   assign mispred_cnt  = r_mispred_cnt;

endmodule

// File: tb/tb_npc_bp.sv
// Self-checking bench for npc_bp: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the fetch/BTB rules.
module tb_npc_bp;

   localparam int PC_W    = 32;
   localparam int IDX_W   = 6;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic             clk;
   logic             reset;
   logic             stall;
   logic [31:0]      F_PC;
   logic             F_pred_taken;
   logic             D_jump;
   logic [31:0]      D_jump_target;
   logic             E_valid;
   logic             E_is_branch;
   logic             E_taken;
   logic             E_pred_taken;
   logic [31:0]      E_PC;
   logic [31:0]      E_target;
   logic             exc_req;
   logic             eret_req;
   logic [31:0]      epc;
   logic             flush_fd;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   logic [31:0] m_pc;
   logic [31:0] m_pt;
   bit          m_pend;
   bit          m_v   [64];
   logic [31:0] m_tag [64];
   logic [31:0] m_tgt [64];
   int          m_ctr [64];
   int          m_br;
   int          m_mp;
   bit          exp_pred;
   bit          exp_flush;

   npc_bp #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .F_PC          (F_PC),
      .F_pred_taken  (F_pred_taken),
      .D_jump        (D_jump),
      .D_jump_target (D_jump_target),
      .E_valid       (E_valid),
      .E_is_branch   (E_is_branch),
      .E_taken       (E_taken),
      .E_pred_taken  (E_pred_taken),
      .E_PC          (E_PC),
      .E_target      (E_target),
      .exc_req       (exc_req),
      .eret_req      (eret_req),
      .epc           (epc),
      .flush_fd      (flush_fd),
      .br_cnt        (br_cnt),
      .mispred_cnt   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 32'd4) % 32'd64);
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_pt = RST_PC; m_pend = 1'b0; m_br = 0; m_mp = 0;
      for (int i = 0; i < 64; i++) begin
         m_v[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
      end
   endtask

   task automatic model_eval();
      int fi;
      bit misp;
      fi = idx_of(m_pc);
      exp_pred = !m_pend && m_v[fi] && (m_tag[fi] == m_pc / 32'd256) && (m_ctr[fi] >= 2);
      misp = E_valid && E_is_branch && (E_taken != E_pred_taken);
      exp_flush = exc_req || eret_req || (misp && !stall);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; D_jump = 1'b0; D_jump_target = 32'd0;
      E_valid = 1'b0; E_is_branch = 1'b0; E_taken = 1'b0; E_pred_taken = 1'b0;
      E_PC = 32'd0; E_target = 32'd0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit pr);
      E_valid = 1'b1; E_is_branch = 1'b1; E_PC = pc; E_target = tgt; E_taken = tk; E_pred_taken = pr;
   endtask

   // One clock edge; the model advances using the inputs held across the edge.
   task automatic tick();
      bit pred, misp;
      int fi, ei;
      model_eval();
      pred = exp_pred;
      fi = idx_of(m_pc);
      misp = E_valid && E_is_branch && (E_taken != E_pred_taken);
      @(posedge clk);
      #1;
      if (exc_req) begin
         m_pc = EXC_PC; m_pend = 1'b0;
      end else if (eret_req) begin
         m_pc = epc; m_pend = 1'b0;
      end else if (misp) begin
         m_pc = E_taken ? E_target : E_PC + 32'd8; m_pend = 1'b0;
      end else if (D_jump && !stall) begin
         m_pc = D_jump_target; m_pend = 1'b0;
      end else if (!stall) begin
         if (m_pend) begin
            m_pc = m_pt; m_pend = 1'b0;
         end else if (pred) begin
            m_pt = m_tgt[fi]; m_pend = 1'b1; m_pc = m_pc + 32'd4;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      if (E_valid && E_is_branch) begin
         ei = idx_of(E_PC);
         if (m_v[ei] && m_tag[ei] == E_PC / 32'd256) begin
            if (E_taken) m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
            else         m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
         end else if (E_taken) begin
            m_v[ei] = 1'b1; m_tag[ei] = E_PC / 32'd256; m_tgt[ei] = E_target; m_ctr[ei] = 2;
         end
         m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
         if (misp) m_mp = (m_mp < CNT_MAX) ? m_mp + 1 : CNT_MAX;
      end
   endtask

   task automatic test_reset();
      repeat (8) tick();
      n_tests++; if (F_PC !== 32'h3020) begin n_fail++; $display("FAIL pre_reset_pc got %h want %h", F_PC, 32'h3020); end
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_tests++; if (F_PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", F_PC, RST_PC); end
      n_tests++; if (F_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", F_pred_taken); end
      n_tests++; if (br_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", br_cnt, mispred_cnt); end
      n_tests++; if (flush_fd !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush_fd); end
      #1 reset = 1'b1;
   endtask

   task automatic test_cold_branch();
      repeat (4) tick();
      n_tests++; if (F_PC !== 32'h3010 || F_pred_taken !== 1'b0) begin n_fail++; $display("FAIL cold_lookup got pc %h pred %b want 3010/0", F_PC, F_pred_taken); end
      tick(); tick();
      drive_br(32'h3010, 32'h3040, 1'b1, 1'b0);
      #1;
      n_tests++; if (flush_fd !== 1'b1) begin n_fail++; $display("FAIL cold_flush got %b want 1", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (F_PC !== 32'h3040) begin n_fail++; $display("FAIL cold_redirect got %h want %h", F_PC, 32'h3040); end
      n_tests++; if (mispred_cnt !== 4'd1 || br_cnt !== 4'd1) begin n_fail++; $display("FAIL cold_cnt got %0d/%0d want 1/1", br_cnt, mispred_cnt); end
   endtask

   task automatic test_trained();
      D_jump = 1'b1; D_jump_target = 32'h3010; tick(); clear_inputs();
      #1;
      n_tests++; if (F_PC !== 32'h3010 || F_pred_taken !== 1'b1) begin n_fail++; $display("FAIL trained_pred got pc %h pred %b want 3010/1", F_PC, F_pred_taken); end
      tick();
      n_tests++; if (F_PC !== 32'h3014 || F_pred_taken !== 1'b0) begin n_fail++; $display("FAIL delay_slot got pc %h pred %b want 3014/0", F_PC, F_pred_taken); end
      tick();
      n_tests++; if (F_PC !== 32'h3040) begin n_fail++; $display("FAIL pend_target got %h want %h", F_PC, 32'h3040); end
      drive_br(32'h3010, 32'h3040, 1'b1, 1'b1);
      #1;
      n_tests++; if (flush_fd !== 1'b0) begin n_fail++; $display("FAIL correct_noflush got %b want 0", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (br_cnt !== 4'd2 || mispred_cnt !== 4'd1) begin n_fail++; $display("FAIL trained_cnt got %0d/%0d want 2/1", br_cnt, mispred_cnt); end
   endtask

   task automatic test_not_taken();
      drive_br(32'h3010, 32'h3040, 1'b0, 1'b1);
      #1;
      n_tests++; if (flush_fd !== 1'b1) begin n_fail++; $display("FAIL nt_flush got %b want 1", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (F_PC !== 32'h3018 || mispred_cnt !== 4'd2) begin n_fail++; $display("FAIL nt_redirect got pc %h mp %0d want 3018/2", F_PC, mispred_cnt); end
      D_jump = 1'b1; D_jump_target = 32'h3010; tick(); clear_inputs();
      #1;
      n_tests++; if (F_pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_wt_pred got %b want 1", F_pred_taken); end
      drive_br(32'h3010, 32'h3040, 1'b0, 1'b1);
      tick(); clear_inputs();
      n_tests++; if (F_PC !== 32'h3018 || mispred_cnt !== 4'd3) begin n_fail++; $display("FAIL nt2_redirect got pc %h mp %0d want 3018/3", F_PC, mispred_cnt); end
      D_jump = 1'b1; D_jump_target = 32'h3010; tick(); clear_inputs();
      #1;
      n_tests++; if (F_pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_wnt_pred got %b want 0", F_pred_taken); end
   endtask

   task automatic test_stall();
      drive_br(32'h3010, 32'h3040, 1'b1, 1'b0); tick(); clear_inputs();
      D_jump = 1'b1; D_jump_target = 32'h3010; tick(); clear_inputs();
      tick();
      n_tests++; if (F_PC !== 32'h3014) begin n_fail++; $display("FAIL stall_pend_pc got %h want %h", F_PC, 32'h3014); end
      stall = 1'b1; tick(); tick();
      n_tests++; if (F_PC !== 32'h3014) begin n_fail++; $display("FAIL stall_hold got %h want %h", F_PC, 32'h3014); end
      stall = 1'b0; tick();
      n_tests++; if (F_PC !== 32'h3040) begin n_fail++; $display("FAIL stall_release got %h want %h", F_PC, 32'h3040); end
      stall = 1'b1; drive_br(32'h3100, 32'h3200, 1'b1, 1'b0);
      #1;
      n_tests++; if (flush_fd !== 1'b0) begin n_fail++; $display("FAIL stall_mispred_flush got %b want 0", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (F_PC !== 32'h3200 || mispred_cnt !== 4'd5) begin n_fail++; $display("FAIL stall_mispred_pc got pc %h mp %0d want 3200/5", F_PC, mispred_cnt); end
   endtask

   task automatic test_exc_eret();
      exc_req = 1'b1; D_jump = 1'b1; D_jump_target = 32'h3300;
      drive_br(32'h3100, 32'h3200, 1'b0, 1'b1);
      #1;
      n_tests++; if (flush_fd !== 1'b1) begin n_fail++; $display("FAIL exc_flush got %b want 1", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (F_PC !== EXC_PC) begin n_fail++; $display("FAIL exc_pc got %h want %h", F_PC, EXC_PC); end
      eret_req = 1'b1; epc = 32'h3024; stall = 1'b1;
      #1;
      n_tests++; if (flush_fd !== 1'b1) begin n_fail++; $display("FAIL eret_flush got %b want 1", flush_fd); end
      tick(); clear_inputs();
      n_tests++; if (F_PC !== 32'h3024) begin n_fail++; $display("FAIL eret_pc got %h want %h", F_PC, 32'h3024); end
   endtask

   task automatic test_wrap();
      D_jump = 1'b1; D_jump_target = 32'hFFFF_FFFC; tick(); clear_inputs();
      tick();
      n_tests++; if (F_PC !== 32'h0000_0000) begin n_fail++; $display("FAIL pc_wrap got %h want 00000000", F_PC); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         stall         = ($urandom_range(0, 4) == 0);
         exc_req       = ($urandom_range(0, 49) == 0);
         eret_req      = ($urandom_range(0, 49) == 0);
         epc           = 32'h3000 + 32'($urandom_range(0, 63)) * 32'd4;
         D_jump        = ($urandom_range(0, 7) == 0);
         D_jump_target = 32'h3000 + 32'($urandom_range(0, 1)) * 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
         E_valid       = 1'($urandom_range(0, 1));
         E_is_branch   = ($urandom_range(0, 2) != 0);
         E_taken       = 1'($urandom_range(0, 1));
         E_pred_taken  = 1'($urandom_range(0, 1));
         E_PC          = 32'h3000 + 32'($urandom_range(0, 1)) * 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
         E_target      = 32'h3000 + 32'($urandom_range(0, 127)) * 32'd4;
         #1;
         model_eval();
         n_tests++; if (F_PC !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", c, F_PC, m_pc); end
         n_tests++; if (F_pred_taken !== exp_pred) begin n_fail++; $display("FAIL rand_pred cyc %0d got %b want %b", c, F_pred_taken, exp_pred); end
         n_tests++; if (flush_fd !== exp_flush) begin n_fail++; $display("FAIL rand_flush cyc %0d got %b want %b", c, flush_fd, exp_flush); end
         n_tests++; if (br_cnt !== 4'(m_br) || mispred_cnt !== 4'(m_mp)) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", c, br_cnt, mispred_cnt, m_br, m_mp); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         drive_br(32'h3000 + 32'(k) * 32'd4, 32'h3080, 1'b1, 1'b0);
         tick();
      end
      clear_inputs();
      n_tests++; if (br_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate got %0d/%0d want 15/15", br_cnt, mispred_cnt); end
      n_tests++; if (m_br != CNT_MAX || m_mp != CNT_MAX) begin n_fail++; $display("FAIL model_saturate got %0d/%0d want 15/15", m_br, m_mp); end
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      test_reset();
      test_cold_branch();
      test_trained();
      test_not_taken();
      test_stall();
      test_exc_eret();
      test_wrap();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
